// File: rtl/multi_operand_adder_pipe_pkg.sv
// Shared sizing helpers and types for the pipelined multi-operand adder.
// The carry width grows with the operand count so the full-precision sum always fits.
package multi_operand_adder_pipe_pkg;

   localparam int DEF_WIDTH   = 32;
   localparam int DEF_NUM_OPS = 3;

   function automatic int calc_cw(input int num_ops);
      return (num_ops <= 2) ? 1 : $clog2(num_ops);
   endfunction

   function automatic int calc_out_w(input int width, input int num_ops);
      return width + calc_cw(num_ops);
   endfunction

   localparam int DEF_OUT_W = calc_out_w(DEF_WIDTH, DEF_NUM_OPS);

   typedef logic [DEF_OUT_W-1:0] res_t;

   typedef struct packed {
      logic acc;
      logic clr;
   } ctrl_t;

endpackage

// File: rtl/multi_operand_adder_pipe_if.sv
// Operand/result bundle with valid/ready on both sides of the adder pipeline.
// slave is the adder's view, master is the producer/consumer view.
interface multi_operand_adder_pipe_if
   import multi_operand_adder_pipe_pkg::*;
#(
   parameter int WIDTH   = DEF_WIDTH,
   parameter int NUM_OPS = DEF_NUM_OPS
);
   localparam int CW = calc_cw(NUM_OPS);

   logic                     in_valid;
   logic                     in_ready;
   logic [NUM_OPS*WIDTH-1:0] in_ops;
   logic                     in_cin;
   logic                     in_acc;
   logic                     in_clr;
   logic                     out_valid;
   logic                     out_ready;
   logic [WIDTH-1:0]         out_sum;
   logic [CW-1:0]            out_cout;
   logic                     acc_ovf;

   modport slave (
      input  in_valid, in_ops, in_cin, in_acc, in_clr, out_ready,
      output in_ready, out_valid, out_sum, out_cout, acc_ovf
   );

   modport master (
      output in_valid, in_ops, in_cin, in_acc, in_clr, out_ready,
      input  in_ready, out_valid, out_sum, out_cout, acc_ovf
   );

endinterface

// File: rtl/multi_operand_adder_pipe_csa_3to2.sv
// One row of 3:2 carry-save compression; the carry vector is pre-shifted into place.
module multi_operand_adder_pipe_csa_3to2 #(
   parameter int W = 8
) (
   input  logic [W-1:0] a,
   input  logic [W-1:0] b,
   input  logic [W-1:0] c,
   output logic [W-1:0] s,
   output logic [W-1:0] co
);

   logic [W-1:0] maj;

   assign s   = a ^ b ^ c;
   assign maj = (a & b) | (a & c) | (b & c);
   // the dropped top carry bit lies above the result width, so the sum is exact mod 2^W
   assign co  = maj << 1;

endmodule

// File: rtl/multi_operand_adder_pipe.sv
// Pipelined NUM_OPS-operand adder with carry-in, full backpressure and running accumulate.
// CSA reduction feeds the first register; the carry-propagate add and accumulate sit in the last stage.
module multi_operand_adder_pipe
   import multi_operand_adder_pipe_pkg::*;
#(
   parameter int WIDTH       = 32,
   parameter int NUM_OPS     = 3,
   parameter int PIPE_STAGES = 2
) (
   input logic                         clk,
   input logic                         rst_n,
   multi_operand_adder_pipe_if.slave   bus
);

   localparam int CW    = calc_cw(NUM_OPS);
   localparam int OUT_W = WIDTH + CW;
   localparam int NV    = NUM_OPS + 1;

   logic             stall;
   logic             out_valid_q;
   logic [OUT_W-1:0] res_q;
   logic [OUT_W-1:0] acc_q;
   logic             ovf_q;

   assign stall = out_valid_q && !bus.out_ready;

   // carry-in rides along as one more operand into the CSA chain
   logic [OUT_W-1:0] opv [NV];

   always_comb begin
      for (int k = 0; k < NUM_OPS; k++) begin
         opv[k] = OUT_W'(bus.in_ops[k*WIDTH +: WIDTH]);
      end
      opv[NUM_OPS] = OUT_W'(bus.in_cin);
   end

   for (genvar g = 0; g < NV - 2; g++) begin : g_lvl
      logic [OUT_W-1:0] s;
      logic [OUT_W-1:0] c;
      if (g == 0) begin : g_first
         multi_operand_adder_pipe_csa_3to2 #(.W(OUT_W)) u_csa (
            .a(opv[0]), .b(opv[1]), .c(opv[2]), .s(s), .co(c)
         );
      end else begin : g_next
         multi_operand_adder_pipe_csa_3to2 #(.W(OUT_W)) u_csa (
            .a(g_lvl[g-1].s), .b(g_lvl[g-1].c), .c(opv[g+2]), .s(s), .co(c)
         );
      end
   end

   logic [OUT_W-1:0] red_s, red_c;
   ctrl_t            in_ctrl;

   assign red_s   = g_lvl[NV-3].s;
   assign red_c   = g_lvl[NV-3].c;
   assign in_ctrl = '{acc: bus.in_acc, clr: bus.in_clr};

   logic             f_valid;
   logic [OUT_W-1:0] f_s, f_c;
   ctrl_t            f_ctrl;

   if (PIPE_STAGES > 1) begin : g_mid
      localparam int NM = PIPE_STAGES - 1;
      logic             v_q   [NM];
      logic [OUT_W-1:0] s_q   [NM];
      logic [OUT_W-1:0] c_q   [NM];
      ctrl_t            ctl_q [NM];

      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            for (int i = 0; i < NM; i++) begin
               v_q[i]   <= 1'b0;
               s_q[i]   <= '0;
               c_q[i]   <= '0;
               ctl_q[i] <= '0;
            end
         end else if (!stall) begin
            v_q[0]   <= bus.in_valid;
            s_q[0]   <= red_s;
            c_q[0]   <= red_c;
            ctl_q[0] <= in_ctrl;
            for (int i = 1; i < NM; i++) begin
               v_q[i]   <= v_q[i-1];
               s_q[i]   <= s_q[i-1];
               c_q[i]   <= c_q[i-1];
               ctl_q[i] <= ctl_q[i-1];
            end
         end
      end

      assign f_valid = v_q[NM-1];
      assign f_s     = s_q[NM-1];
      assign f_c     = c_q[NM-1];
      assign f_ctrl  = ctl_q[NM-1];
   end else begin : g_direct
      assign f_valid = bus.in_valid;
      assign f_s     = red_s;
      assign f_c     = red_c;
      assign f_ctrl  = in_ctrl;
   end

   logic [OUT_W-1:0] r_cpa, acc_base;
   logic [OUT_W:0]   acc_sum;
   logic             ovf_base;

   assign r_cpa    = f_s + f_c;
   assign acc_base = f_ctrl.clr ? '0 : acc_q;
   assign acc_sum  = {1'b0, acc_base} + {1'b0, r_cpa};
   assign ovf_base = !f_ctrl.clr && ovf_q;

   // acc_q is only touched on final-stage loads, so adjacent accumulates chain through it directly
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid_q <= 1'b0;
         res_q       <= '0;
         acc_q       <= '0;
         ovf_q       <= 1'b0;
      end else if (!stall) begin
         out_valid_q <= f_valid;
         if (f_valid) begin
            if (f_ctrl.acc) begin
               res_q <= acc_sum[OUT_W-1:0];
               acc_q <= acc_sum[OUT_W-1:0];
               ovf_q <= ovf_base | acc_sum[OUT_W];
            end else begin
               res_q <= r_cpa;
               acc_q <= acc_base;
               ovf_q <= ovf_base;
            end
         end
      end
   end

   assign bus.in_ready  = !stall;
   assign bus.out_valid = out_valid_q;
   assign bus.out_sum   = res_q[WIDTH-1:0];
   assign bus.out_cout  = res_q[OUT_W-1:WIDTH];
   assign bus.acc_ovf   = ovf_q;

endmodule

// File: tb/tb_multi_operand_adder_pipe.sv
// Directed bench for multi_operand_adder_pipe: vector table, streaming with stall, chaining and reset.
module tb_multi_operand_adder_pipe;
   import multi_operand_adder_pipe_pkg::*;

   logic clk;
   logic rst_n;
   int   errors;
   int   checks;

   multi_operand_adder_pipe_if #(.WIDTH(32), .NUM_OPS(3)) bus ();

   multi_operand_adder_pipe #(.WIDTH(32), .NUM_OPS(3), .PIPE_STAGES(2)) dut (
      .clk(clk), .rst_n(rst_n), .bus(bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] op0, op1, op2;
      logic        cin, acc, clr;
      logic [31:0] esum;
      logic [1:0]  ecout;
      logic        eovf;
   } vec_t;

   typedef struct {
      res_t res;
      logic ovf;
   } sb_t;

   sb_t        sb [$];
   res_t       macc;
   logic       movf;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // reference model: consume outputs in order, predict each accepted bundle
   always @(negedge clk or negedge rst_n) begin
      logic [35:0] r;
      logic [34:0] t;
      logic [33:0] base;
      sb_t         e;
      if (!rst_n) begin
         sb.delete();
         macc = '0;
         movf = 1'b0;
      end else begin
         if (bus.out_valid && bus.out_ready) begin
            check("sb_nonempty", (sb.size() != 0), 1);
            if (sb.size() != 0) begin
               e = sb.pop_front();
               check("sb_sum", bus.out_sum, e.res[31:0]);
               check("sb_cout", bus.out_cout, e.res[33:32]);
               check("sb_ovf", bus.acc_ovf, e.ovf);
            end
         end
         if (bus.in_valid && bus.in_ready) begin
            r = 36'(bus.in_ops[31:0]) + 36'(bus.in_ops[63:32]) + 36'(bus.in_ops[95:64]) + 36'(bus.in_cin);
            base = bus.in_clr ? 34'd0 : macc;
            movf = bus.in_clr ? 1'b0 : movf;
            if (bus.in_acc) begin
               t = 35'(base) + 35'(r[33:0]);
               e.res = t[33:0];
               macc = t[33:0];
               movf = movf | t[34];
            end else begin
               e.res = r[33:0];
               macc = base;
            end
            e.ovf = movf;
            sb.push_back(e);
         end
      end
   end

   task automatic apply_vec(input vec_t v, input string name);
      int lat;
      check({name, "_in_ready"}, bus.in_ready, 1);
      bus.in_ops   = {v.op2, v.op1, v.op0};
      bus.in_cin   = v.cin;
      bus.in_acc   = v.acc;
      bus.in_clr   = v.clr;
      bus.in_valid = 1'b1;
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
      lat = 0;
      while (!bus.out_valid && lat < 10) begin
         @(posedge clk); #1;
         lat++;
      end
      check({name, "_latency"}, lat, 1);
      check({name, "_sum"}, bus.out_sum, v.esum);
      check({name, "_cout"}, bus.out_cout, v.ecout);
      check({name, "_ovf"}, bus.acc_ovf, v.eovf);
   endtask

   task automatic stream(input int n, input int stall_at);
      int          i;
      int          cyc;
      logic        acc_now;
      logic [31:0] held;
      i = 0; cyc = 0; held = '0;
      while (i < n && cyc < 100) begin
         bus.in_ops    = {~32'(i), 32'hFFFF_FFF0 + 32'(i), 32'(i) * 32'h0101_0101};
         bus.in_cin    = i[0];
         bus.in_acc    = i[1];
         bus.in_clr    = 1'b0;
         bus.in_valid  = 1'b1;
         bus.out_ready = !(cyc >= stall_at && cyc < stall_at + 5);
         @(negedge clk);
         acc_now = bus.in_ready;
         if (stall_at < 0) begin
            check("stream_in_ready", acc_now, 1);
         end else if (cyc >= stall_at && cyc < stall_at + 5) begin
            check("stall_in_ready", acc_now, 0);
            check("stall_out_valid", bus.out_valid, 1);
            if (cyc == stall_at) held = bus.out_sum;
            else check("stall_hold", bus.out_sum, held);
         end
         @(posedge clk); #1;
         if (acc_now) i++;
         cyc++;
      end
      check("stream_count", i, n);
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b1;
      cyc = 0;
      while (sb.size() != 0 && cyc < 50) begin
         @(posedge clk); #1;
         cyc++;
      end
      check("stream_drain", sb.size(), 0);
   endtask

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

   initial begin
      vec_t vt [15];
      vec_t rv;
      errors = 0;
      checks = 0;

      vt[0]  = '{32'd1, 32'd3, 32'd1, 1'b0, 1'b0, 1'b0, 32'h0000_0005, 2'd0, 1'b0};
      vt[1]  = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1'b0, 1'b0, 32'hFFFF_FFFE, 2'd2, 1'b0};
      vt[2]  = '{32'd0, 32'd0, 32'd0, 1'b1, 1'b0, 1'b0, 32'h0000_0001, 2'd0, 1'b0};
      vt[3]  = '{32'hFFFF_FFFF, 32'd1, 32'd0, 1'b0, 1'b0, 1'b0, 32'h0000_0000, 2'd1, 1'b0};
      vt[4]  = '{32'h8000_0000, 32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0, 1'b0, 32'h8000_0000, 2'd1, 1'b0};
      vt[5]  = '{32'd2, 32'd2, 32'd1, 1'b0, 1'b1, 1'b1, 32'h0000_0005, 2'd0, 1'b0};
      vt[6]  = '{32'd3, 32'd3, 32'd1, 1'b0, 1'b1, 1'b0, 32'h0000_000C, 2'd0, 1'b0};
      vt[7]  = '{32'd10, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0, 32'h0000_000A, 2'd0, 1'b0};
      vt[8]  = '{32'd0, 32'd0, 32'd0, 1'b0, 1'b1, 1'b0, 32'h0000_000C, 2'd0, 1'b0};
      vt[9]  = '{32'd7, 32'd0, 32'd0, 1'b0, 1'b0, 1'b1, 32'h0000_0007, 2'd0, 1'b0};
      vt[10] = '{32'd1, 32'd0, 32'd0, 1'b0, 1'b1, 1'b0, 32'h0000_0001, 2'd0, 1'b0};
      vt[11] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1'b1, 1'b1, 32'hFFFF_FFFE, 2'd2, 1'b0};
      vt[12] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1'b1, 1'b0, 32'hFFFF_FFFC, 2'd1, 1'b1};
      vt[13] = '{32'd1, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0, 32'h0000_0001, 2'd0, 1'b1};
      vt[14] = '{32'd0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b1, 32'h0000_0000, 2'd0, 1'b0};
      rv     = '{32'd1, 32'd2, 32'd3, 1'b0, 1'b1, 1'b0, 32'h0000_0006, 2'd0, 1'b0};

      rst_n         = 1'b0;
      bus.in_valid  = 1'b0;
      bus.in_ops    = '0;
      bus.in_cin    = 1'b0;
      bus.in_acc    = 1'b0;
      bus.in_clr    = 1'b0;
      bus.out_ready = 1'b1;
      #12;
      rst_n = 1'b1;
      #1;
      check("rst_out_valid", bus.out_valid, 0);
      check("rst_out_sum", bus.out_sum, 0);
      check("rst_out_cout", bus.out_cout, 0);
      check("rst_acc_ovf", bus.acc_ovf, 0);
      check("rst_in_ready", bus.in_ready, 1);
      @(posedge clk); #1;

      for (int k = 0; k < 15; k++) begin
         apply_vec(vt[k], $sformatf("vec%0d", k));
      end

      // adjacent-cycle accumulate chaining
      bus.in_ops = {32'd1, 32'd2, 32'd2};
      bus.in_cin = 1'b0; bus.in_acc = 1'b1; bus.in_clr = 1'b1; bus.in_valid = 1'b1;
      @(posedge clk); #1;
      bus.in_ops = {32'd1, 32'd3, 32'd3};
      bus.in_clr = 1'b0;
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
      check("chain_valid0", bus.out_valid, 1);
      check("chain_sum0", bus.out_sum, 32'h5);
      @(posedge clk); #1;
      check("chain_valid1", bus.out_valid, 1);
      check("chain_sum1", bus.out_sum, 32'hC);
      check("chain_ovf", bus.acc_ovf, 0);
      @(posedge clk); #1;

      stream(10, -100);
      stream(12, 4);

      // reset with two accumulate entries in flight
      apply_vec(vt[11], "pre_rst0");
      apply_vec(vt[12], "pre_rst1");
      bus.in_ops = {32'd5, 32'd5, 32'd5};
      bus.in_cin = 1'b0; bus.in_acc = 1'b1; bus.in_clr = 1'b0; bus.in_valid = 1'b1;
      @(posedge clk); #1;
      bus.in_ops = {32'd9, 32'd9, 32'd9};
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
      check("inflight_valid", bus.out_valid, 1);
      #2;
      rst_n = 1'b0;
      #1;
      check("async_rst_valid", bus.out_valid, 0);
      check("async_rst_ovf", bus.acc_ovf, 0);
      check("async_rst_sum", bus.out_sum, 0);
      check("async_rst_ready", bus.in_ready, 1);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      for (int k = 0; k < 3; k++) begin
         @(posedge clk); #1;
         check("post_rst_no_stale", bus.out_valid, 0);
      end
      apply_vec(rv, "post_rst_acc");
      @(posedge clk); #1;
      check("final_sb_empty", sb.size(), 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
